// File: rtl/shift_register_n.sv
// WIDTH-bit load/shift/rotate register with serial in/out and a multi-step
// "shift by AMT" sequencer that reports progress on BUSY and completion on DONE.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] DATA,
  input  logic             SIN,
  input  logic             START,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] R,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sout;
  } step_t;

  // One step of any operation; SOUT only moves when a bit leaves the word.
  function automatic step_t do_step(input logic [2:0]       op,
                                    input logic [WIDTH-1:0] cur,
                                    input logic [WIDTH-1:0] load,
                                    input logic             sin,
                                    input logic             sout);
    step_t s;
    s.data = cur;
    s.sout = sout;
    case (op)
      OP_LOAD:  s.data = load;
      OP_SHL:   begin s.data = {cur[WIDTH-2:0], sin};          s.sout = cur[WIDTH-1]; end
      OP_SHR:   begin s.data = {sin, cur[WIDTH-1:1]};          s.sout = cur[0];       end
      OP_ROL:   begin s.data = {cur[WIDTH-2:0], cur[WIDTH-1]}; s.sout = cur[WIDTH-1]; end
      OP_ROR:   begin s.data = {cur[0], cur[WIDTH-1:1]};       s.sout = cur[0];       end
      OP_ASR:   begin s.data = {cur[WIDTH-1], cur[WIDTH-1:1]}; s.sout = cur[0];       end
      OP_CLEAR: s.data = '0;
      default:  ;
    endcase
    return s;
  endfunction

  state_e           r_state;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  logic  w_is_seq;
  step_t w_step_live;
  step_t w_step_seq;

  assign w_is_seq    = (OP inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});
  assign w_step_live = do_step(OP,   r_data, DATA, SIN, r_sout);
  assign w_step_seq  = do_step(r_op, r_data, DATA, SIN, r_sout);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: the default below is overridden later in this block; with
      // non-blocking assignments the last write in program order wins.
      r_done <= 1'b0;
      case (r_state)
        ST_SHIFT: begin
          r_data <= w_step_seq.data;
          r_sout <= w_step_seq.sout;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == AW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (START && w_is_seq) begin
            r_op <= OP;
            if (AMT != '0) begin
              r_data <= w_step_live.data;
              r_sout <= w_step_live.sout;
            end
            // Counts of 0 and 1 finish at this edge and never raise BUSY.
            if (AMT <= AW'(1)) begin
              r_done <= 1'b1;
            end else begin
              r_cnt   <= AMT - 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end
          end else if (START || ENA) begin
            r_data <= w_step_live.data;
            r_sout <= w_step_live.sout;
          end
        end
      endcase
    end
  end

  assign R    = r_data;
  assign SOUT = r_sout;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_shift_register_n.sv
// Bench for shift_register_n: directed scenarios plus random traffic, every
// cycle compared against an arithmetic model of the register and its sequencer.
module tb_shift_register_n;

  localparam int W    = 8;
  localparam int AWID = 4;
  localparam int MASK = (1 << W) - 1;

  logic            CLK;
  logic            RST;
  logic            ENA;
  logic [2:0]      OP;
  logic [W-1:0]    DATA;
  logic            SIN;
  logic            START;
  logic [AWID-1:0] AMT;
  logic [W-1:0]    R;
  logic            SOUT;
  logic            BUSY;
  logic            DONE;

  shift_register_n #(.WIDTH(W), .AW(AWID)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .OP(OP), .DATA(DATA), .SIN(SIN),
    .START(START), .AMT(AMT), .R(R), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: word value, last bit out, steps still owed, latched op.
  int m_r    = 0;
  int m_sout = 0;
  int m_left = 0;
  int m_op   = 0;
  int m_done = 0;

  int n_done = 0;
  int n_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_apply(input int op, input int sin, input int data);
    int msb;
    int lsb;
    msb = (m_r >> (W - 1)) & 1;
    lsb = m_r & 1;
    case (op)
      1: m_r = data & MASK;
      2: begin m_sout = msb; m_r = ((m_r << 1) | sin) & MASK;     end
      3: begin m_sout = lsb; m_r = (m_r >> 1) | (sin << (W - 1)); end
      4: begin m_sout = msb; m_r = ((m_r << 1) | msb) & MASK;     end
      5: begin m_sout = lsb; m_r = (m_r >> 1) | (lsb << (W - 1)); end
      6: begin m_sout = lsb; m_r = (m_r >> 1) | (msb << (W - 1)); end
      7: m_r = 0;
      default: ;
    endcase
  endtask

  task automatic tick(input bit rst, input bit ena, input int op, input int data,
                      input bit sin, input bit start, input int amt);
    RST   = rst;
    ENA   = ena;
    OP    = 3'(op);
    DATA  = W'(data);
    SIN   = sin;
    START = start;
    AMT   = AWID'(amt);
    if (rst) begin
      m_r = 0; m_sout = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_apply(m_op, sin, 0);
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (start && op >= 2 && op <= 6) begin
        m_op = op;
        if (amt > 0) begin
          m_apply(op, sin, data);
          m_left = amt - 1;
        end
        if (m_left == 0) m_done = 1;
      end else if (start || ena) begin
        m_apply(op, sin, data);
      end
    end
    @(posedge CLK);
    #1;
    check("R", 32'(R), 32'(m_r));
    check("SOUT", 32'(SOUT), 32'(m_sout));
    check("BUSY", 32'(BUSY), (m_left > 0) ? 32'd1 : 32'd0);
    check("DONE", 32'(DONE), 32'(m_done));
    n_done += int'(DONE);
    n_busy += int'(BUSY);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic load(input int v);
    tick(1'b0, 1'b1, 1, v, 1'b0, 1'b0, 0);
  endtask

  initial begin
    bit [7:0] pattern;
    RST = 1'b1; ENA = 1'b0; OP = '0; DATA = '0; SIN = 1'b0; START = 1'b0; AMT = '0;

    // Reset with a load pending, then the load lands and holds.
    tick(1'b1, 1'b1, 1, 'h3C, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b1, 1, 'h3C, 1'b0, 1'b0, 0);
    check("rst_R", 32'(R), 32'h00);
    check("rst_BUSY", 32'(BUSY), 32'd0);
    tick(1'b0, 1'b1, 1, 'h3C, 1'b0, 1'b0, 0);
    check("load_R", 32'(R), 32'h3C);
    for (int i = 0; i < 5; i++) idle();
    check("hold_R", 32'(R), 32'h3C);

    // Serial shift-in, MSB first.
    tick(1'b0, 1'b1, 7, 0, 1'b0, 1'b0, 0);
    pattern = 8'b1011_0010;
    n_done = 0;
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, 2, 0, pattern[i], 1'b0, 0);
    check("ser_R", 32'(R), 32'hB2);
    check("ser_done", 32'(n_done), 32'd0);

    // Multi-cycle rotate left by 3.
    load('hA5);
    tick(1'b0, 1'b0, 4, 0, 1'b0, 1'b1, 3);
    check("rol_busy0", 32'(BUSY), 32'd1);
    idle();
    check("rol_busy1", 32'(BUSY), 32'd1);
    idle();
    check("rol_R", 32'(R), 32'h2D);
    check("rol_done", 32'(DONE), 32'd1);
    check("rol_sout", 32'(SOUT), 32'd1);
    idle();
    check("rol_done_off", 32'(DONE), 32'd0);

    // ASR by 2 with commands thrown at it while busy.
    load('h90);
    n_done = 0;
    tick(1'b0, 1'b0, 6, 0, 1'b0, 1'b1, 2);
    tick(1'b0, 1'b1, 1, 'h00, 1'b1, 1'b1, 5);
    check("asr_R", 32'(R), 32'hE4);
    check("asr_sout", 32'(SOUT), 32'd0);
    for (int i = 0; i < 3; i++) idle();
    check("asr_ndone", 32'(n_done), 32'd1);

    // Zero-length sequence.
    load('h5A);
    n_busy = 0;
    tick(1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 0);
    check("amt0_R", 32'(R), 32'h5A);
    check("amt0_done", 32'(DONE), 32'd1);
    check("amt0_busy", 32'(n_busy), 32'd0);

    // Full-width rotation returns the original word.
    load('h81);
    n_busy = 0;
    tick(1'b0, 1'b0, 4, 0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 7; i++) idle();
    check("rol8_busy", 32'(n_busy), 32'd7);
    check("rol8_R", 32'(R), 32'h81);
    check("rol8_done", 32'(DONE), 32'd1);

    // Reset during the third busy cycle aborts without DONE.
    load('hFF);
    tick(1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 6);
    idle();
    idle();
    tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    check("abort_R", 32'(R), 32'h00);
    check("abort_busy", 32'(BUSY), 32'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) idle();
    check("abort_ndone", 32'(n_done), 32'd0);

    // Random traffic, including long counts and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_n.md
Name: shift_register_n

Overview:
- Parametrised successor to the team's fixed 8-bit load-enable register.
- Holds a WIDTH-bit word. Supports single-cycle load/hold/clear and shift/rotate ops with serial in/out.
- Adds a multi-cycle "shift by AMT" sequencer with a BUSY/DONE handshake.
- Used as a datapath register and as a serialiser/deserialiser next to the existing register and flip-flop library.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AW, 4, width of AMT. Must satisfy 2^AW > WIDTH, so shift counts 0..WIDTH are expressible.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- ENA  input  1  enables a single-cycle OP when idle.
- OP  input  3  operation select.
- DATA  input  WIDTH  parallel load value.
- SIN  input  1  serial input bit for SHL/SHR.
- START  input  1  starts a multi-cycle shift of AMT steps using OP.
- AMT  input  AW  number of shift steps for START.
- R  output  WIDTH  registered contents.
- SOUT  output  1  registered copy of the last bit shifted or rotated out.
- BUSY  output  1  multi-cycle sequence in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- All state changes on rising CLK. Reset values: R=0, SOUT=0, BUSY=0, DONE=0, FSM=IDLE.
- OP encoding (one "step"):
  - 000 HOLD
  - 001 LOAD: R<=DATA
  - 010 SHL: R<={R[W-2:0],SIN}, SOUT<=R[W-1]
  - 011 SHR: R<={SIN,R[W-1:1]}, SOUT<=R[0]
  - 100 ROL: R<={R[W-2:0],R[W-1]}, SOUT<=R[W-1]
  - 101 ROR: R<={R[0],R[W-1:1]}, SOUT<=R[0]
  - 110 ASR: R<={R[W-1],R[W-1:1]}, SOUT<=R[0]
  - 111 CLEAR: R<=0, SOUT unchanged
- SOUT changes only on shift/rotate steps.
- Priority per edge: RST > active SHIFT sequence > START > ENA op > hold.
- FSM states: IDLE, SHIFT.
- IDLE, START=1, OP in 010..110, AMT=N:
  - OP latched internally. First step executes at this same edge.
  - N=0: R and SOUT unchanged; DONE=1 next cycle; BUSY stays 0; stay IDLE.
  - N=1: one step executes; DONE=1 next cycle; BUSY stays 0; stay IDLE.
  - N>=2: one step executes; remaining count <= N-1; BUSY<=1; go to SHIFT.
- SHIFT, each edge:
  - One step using the latched OP. SIN is sampled live on every step (serial stream).
  - Count decrements. On the final step: BUSY<=0, DONE<=1, go to IDLE.
  - Net timing: START at edge k gives steps at edges k..k+N-1; DONE is high for exactly the cycle after edge k+N-1.
- START with OP in {000,001,111}: treated as the equivalent single-cycle op. No BUSY, no DONE.
- IDLE, START=0, ENA=1: execute OP once. No DONE.
- While BUSY=1: START, ENA, OP, DATA and AMT are ignored. No queuing.
- DONE is a pulse; it deasserts after one cycle unless a new sequence completes.
- In the DONE cycle the FSM is IDLE, so a new START or ENA is accepted that cycle.
- AMT > WIDTH is legal: steps simply continue (rotations wrap, shifts fill).
- RST mid-sequence: next edge R=0, SOUT=0, BUSY=0, DONE=0, IDLE. The aborted sequence produces no DONE.
- START and ENA together in IDLE: START wins; ENA is ignored.

Test Plan:
- Reset and load: assert RST 2 cycles, then ENA=1, OP=001, DATA=8'h3C -> R=8'h00, SOUT=0, BUSY=0, DONE=0 during reset; R=8'h3C after next edge; ENA=0 then holds 3C for 5 cycles.
- Serial shift-in: R=0; ENA=1, OP=010, SIN pattern 1,0,1,1,0,0,1,0 (MSB first) over 8 cycles -> R=8'hB2; DONE never asserts.
- Multi-cycle rotate: R=8'hA5; START=1, OP=100, AMT=3 -> BUSY high after edges k and k+1, R=8'h2D after edge k+2, DONE high one cycle, SOUT=1.
- Arithmetic shift and ignored commands: R=8'h90; START, OP=110, AMT=2; during BUSY pulse START with AMT=5 and ENA with OP=001 -> final R=8'hE4, SOUT=0, exactly one DONE pulse.
- Boundaries:
  - AMT=0 on R=8'h5A -> R unchanged, DONE pulses, BUSY stays 0.
  - ROL with AMT=8 on R=8'h81 -> BUSY high 7 cycles, R=8'h81 at DONE.
- Reset mid-sequence: R=8'hFF, START, OP=011, AMT=6, SIN=0; RST at 3rd busy cycle -> next edge R=0, BUSY=0, DONE stays 0 for 10 cycles after.
